// File: rtl/move_if.sv
// Move request / result bundle between the coordinate selector side and move_executor.
// master: drives the request and the display read address; slave: the executor.
// Ports: go, x1/y1/x2/y2, rd_x/rd_y (request side); rd_piece, turn, busy, move_ok,
//        move_err, err_code, rearm_n (result side).
interface move_if #(
    parameter int CELL_W = 2
);
    logic              go;
    logic [3:0]        x1;
    logic [3:0]        y1;
    logic [3:0]        x2;
    logic [3:0]        y2;
    logic [3:0]        rd_x;
    logic [3:0]        rd_y;
    logic [CELL_W-1:0] rd_piece;
    logic              turn;
    logic              busy;
    logic              move_ok;
    logic              move_err;
    logic [2:0]        err_code;
    logic              rearm_n;

    modport master (
        output go, x1, y1, x2, y2, rd_x, rd_y,
        input  rd_piece, turn, busy, move_ok, move_err, err_code, rearm_n
    );

    modport slave (
        input  go, x1, y1, x2, y2, rd_x, rd_y,
        output rd_piece, turn, busy, move_ok, move_err, err_code, rearm_n
    );
endinterface

// File: rtl/move_executor.sv
// Validates and commits a board move (x1,y1)->(x2,y2) on the rising edge of go.
// Latency: valid move -> move_ok 2 cycles after start, idle after 4; invalid -> move_err after 1, idle after 3.
// Backpressure: a go rise while busy is dropped, never queued; rearm_n pulses low after each result.
// Ports: clk, rst (async, active-low), bus (move_if.slave: request, result and display read port).
module move_executor #(
    parameter int GRID   = 8,
    parameter int CELL_W = 2
) (
    input  logic   clk,
    input  logic   rst,
    move_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_REARM  = 3'd4;

    localparam int         NCELL = GRID * GRID;
    localparam int         IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam logic [4:0] GRID5 = 5'(GRID);

    logic [2:0]        state;
    logic              go_q;
    logic [3:0]        sx, sy, dx, dy;
    logic              turn;
    logic [2:0]        err_code;
    logic [CELL_W-1:0] board [NCELL];

    logic              start;
    logic              range_ok;
    logic [IW-1:0]     src_idx, dst_idx, rd_idx;
    logic [CELL_W-1:0] own;
    logic [2:0]        chk_err;
    logic              rd_ok;

    function automatic logic in_rng(input logic [3:0] c);
        return {1'b0, c} < GRID5;
    endfunction

    // Only meaningful once both coordinates passed in_rng.
    function automatic logic [IW-1:0] lin(input logic [3:0] x, input logic [3:0] y);
        return IW'(y) * IW'(GRID) + IW'(x);
    endfunction

    function automatic logic [CELL_W-1:0] init_cell(input int i);
        int r;
        r = i / GRID;
        if (r < 2)              return CELL_W'(1);
        else if (r >= GRID - 2) return CELL_W'(2);
        else                    return '0;
    endfunction

    assign start = bus.go & ~go_q;

    always_comb begin
        range_ok = in_rng(sx) && in_rng(sy) && in_rng(dx) && in_rng(dy);
        // Indices are forced to 0 until the range check passes so no access ever leaves the board.
        src_idx  = range_ok ? lin(sx, sy) : '0;
        dst_idx  = range_ok ? lin(dx, dy) : '0;
        own      = turn ? CELL_W'(2) : CELL_W'(1);
        chk_err  = 3'd0;
        if (!range_ok)                      chk_err = 3'd1;
        else if (sx == dx && sy == dy)      chk_err = 3'd2;
        else if (board[src_idx] != own)     chk_err = 3'd3;
        else if (board[dst_idx] == own)     chk_err = 3'd4;
    end

    always_comb begin
        rd_ok        = in_rng(bus.rd_x) && in_rng(bus.rd_y);
        rd_idx       = rd_ok ? lin(bus.rd_x, bus.rd_y) : '0;
        bus.rd_piece = rd_ok ? board[rd_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            go_q     <= 1'b0;
            turn     <= 1'b0;
            err_code <= 3'd0;
            sx       <= 4'd0;
            sy       <= 4'd0;
            dx       <= 4'd0;
            dy       <= 4'd0;
        end else begin
            go_q <= bus.go;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sx    <= bus.x1;
                        sy    <= bus.y1;
                        dx    <= bus.x2;
                        dy    <= bus.y2;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err != 3'd0) begin
                        err_code <= chk_err;
                        state    <= S_REPORT;
                    end else begin
                        state    <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    turn     <= ~turn;
                    err_code <= 3'd0;
                    state    <= S_REPORT;
                end
                S_REPORT: state <= S_REARM;
                S_REARM:  state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Both halves of the move land on the same edge, so a reset can never split a piece.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCELL; i++) board[i] <= init_cell(i);
        end else if (state == S_COMMIT) begin
            board[dst_idx] <= board[src_idx];
            board[src_idx] <= '0;
        end
    end

    // err_code is 0 in REPORT exactly when the move went through COMMIT.
    assign bus.turn     = turn;
    assign bus.err_code = err_code;
    assign bus.busy     = (state != S_IDLE);
    assign bus.move_ok  = (state == S_REPORT) && (err_code == 3'd0);
    assign bus.move_err = (state == S_REPORT) && (err_code != 3'd0);
    assign bus.rearm_n  = (state != S_REARM);
endmodule

// File: tb/tb_move_executor.sv
module tb_move_executor;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    move_if #(.CELL_W(2)) bus ();

    move_executor #(.GRID(8), .CELL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.go = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rd(input logic [3:0] x, input logic [3:0] y, output logic [1:0] v);
        bus.rd_x = x;
        bus.rd_y = y;
        #1;
        v = bus.rd_piece;
    endtask

    // Sample i is taken 1 time unit after the i-th edge counted from the start edge E0.
    task automatic run_move(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input int hold,
                            output int ok_at, output int err_at, output int rearm_at,
                            output int idle_at, output int ok_n, output int err_n,
                            output int rearm_cnt);
        ok_at = -1; err_at = -1; rearm_at = -1; idle_at = -1;
        ok_n = 0; err_n = 0; rearm_cnt = 0;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        bus.x1 = a; bus.y1 = b; bus.x2 = c; bus.y2 = d;
        bus.go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.move_ok)  begin ok_n++;  if (ok_at < 0) ok_at = i; end
            if (bus.move_err) begin err_n++; if (err_at < 0) err_at = i; end
            if (!bus.rearm_n) begin rearm_cnt++; if (rearm_at < 0) rearm_at = i; end
            if (!bus.busy && idle_at < 0) idle_at = i;
            if (i == hold) bus.go = 1'b0;
        end
        bus.go = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] v;
        do_reset();
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.turn !== 1'b0)     begin n_fail++; $display("FAIL reset_turn got %b want 0", bus.turn); end
        n_cmp++; if (bus.err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", bus.err_code); end
        n_cmp++; if (bus.move_ok !== 1'b0 || bus.move_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got ok=%b err=%b want 0 0", bus.move_ok, bus.move_err); end
        n_cmp++; if (bus.rearm_n !== 1'b1)  begin n_fail++; $display("FAIL reset_rearm got %b want 1", bus.rearm_n); end
        rd(4'd0, 4'd0, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL reset_rd00 got %0d want 1", v); end
        rd(4'd3, 4'd1, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL reset_rd31 got %0d want 1", v); end
        rd(4'd2, 4'd3, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL reset_rd23 got %0d want 0", v); end
        rd(4'd7, 4'd6, v); n_cmp++; if (v !== 2'd2) begin n_fail++; $display("FAIL reset_rd76 got %0d want 2", v); end
        rd(4'd7, 4'd7, v); n_cmp++; if (v !== 2'd2) begin n_fail++; $display("FAIL reset_rd77 got %0d want 2", v); end
        rd(4'd8, 4'd0, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL reset_rd_oor_x got %0d want 0", v); end
        rd(4'd0, 4'd9, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL reset_rd_oor_y got %0d want 0", v); end
    endtask

    task automatic test_valid_move();
        int ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt;
        logic [1:0] v;
        do_reset();
        run_move(4'd0, 4'd1, 4'd0, 4'd2, 1, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        n_cmp++; if (ok_at !== 2 || ok_n !== 1) begin n_fail++; $display("FAIL valid_ok got at=%0d n=%0d want at=2 n=1", ok_at, ok_n); end
        n_cmp++; if (err_n !== 0)               begin n_fail++; $display("FAIL valid_no_err got %0d want 0", err_n); end
        n_cmp++; if (rearm_at !== 3 || rearm_cnt !== 1) begin n_fail++; $display("FAIL valid_rearm got at=%0d n=%0d want at=3 n=1", rearm_at, rearm_cnt); end
        n_cmp++; if (idle_at !== 4)             begin n_fail++; $display("FAIL valid_idle got %0d want 4", idle_at); end
        rd(4'd0, 4'd2, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL valid_dst got %0d want 1", v); end
        rd(4'd0, 4'd1, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL valid_src got %0d want 0", v); end
        n_cmp++; if (bus.turn !== 1'b1)     begin n_fail++; $display("FAIL valid_turn got %b want 1", bus.turn); end
        n_cmp++; if (bus.err_code !== 3'd0) begin n_fail++; $display("FAIL valid_err_code got %0d want 0", bus.err_code); end
    endtask

    task automatic test_wrong_piece();
        int ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt;
        logic [1:0] v;
        do_reset();
        run_move(4'd0, 4'd6, 4'd0, 4'd5, 1, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        n_cmp++; if (err_at !== 1 || err_n !== 1) begin n_fail++; $display("FAIL wrong_err got at=%0d n=%0d want at=1 n=1", err_at, err_n); end
        n_cmp++; if (ok_n !== 0)                  begin n_fail++; $display("FAIL wrong_no_ok got %0d want 0", ok_n); end
        n_cmp++; if (bus.err_code !== 3'd3)       begin n_fail++; $display("FAIL wrong_code got %0d want 3", bus.err_code); end
        n_cmp++; if (rearm_at !== 2 || rearm_cnt !== 1) begin n_fail++; $display("FAIL wrong_rearm got at=%0d n=%0d want at=2 n=1", rearm_at, rearm_cnt); end
        n_cmp++; if (idle_at !== 3)               begin n_fail++; $display("FAIL wrong_idle got %0d want 3", idle_at); end
        n_cmp++; if (bus.turn !== 1'b0)           begin n_fail++; $display("FAIL wrong_turn got %b want 0", bus.turn); end
        rd(4'd0, 4'd6, v); n_cmp++; if (v !== 2'd2) begin n_fail++; $display("FAIL wrong_src got %0d want 2", v); end
        rd(4'd0, 4'd5, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL wrong_dst got %0d want 0", v); end
    endtask

    task automatic test_errors();
        int ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt;
        logic [3:0] vec [5][4];
        logic [2:0] want [5];
        logic [1:0] v;
        vec[0] = '{4'd9, 4'd0, 4'd0, 4'd0}; want[0] = 3'd1;
        vec[1] = '{4'd0, 4'd1, 4'd0, 4'd8}; want[1] = 3'd1;
        vec[2] = '{4'd3, 4'd3, 4'd3, 4'd3}; want[2] = 3'd2;
        vec[3] = '{4'd3, 4'd3, 4'd3, 4'd4}; want[3] = 3'd3;
        vec[4] = '{4'd0, 4'd0, 4'd0, 4'd1}; want[4] = 3'd4;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_move(vec[k][0], vec[k][1], vec[k][2], vec[k][3], 1,
                     ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
            n_cmp++;
            if (bus.err_code !== want[k] || err_n !== 1 || ok_n !== 0) begin
                n_fail++;
                $display("FAIL errors_%0d got code=%0d err_n=%0d ok_n=%0d want code=%0d err_n=1 ok_n=0",
                         k, bus.err_code, err_n, ok_n, want[k]);
            end
        end
        rd(4'd0, 4'd1, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL errors_board got %0d want 1", v); end
    endtask

    task automatic test_capture();
        int ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt;
        int ok_total;
        logic [1:0] v;
        do_reset();
        ok_total = 0;
        run_move(4'd0, 4'd0, 4'd0, 4'd1, 1, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        run_move(4'd0, 4'd1, 4'd0, 4'd5, 1, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        ok_total += ok_n;
        n_cmp++; if (bus.err_code !== 3'd0) begin n_fail++; $display("FAIL capture_code_clear got %0d want 0", bus.err_code); end
        run_move(4'd1, 4'd6, 4'd0, 4'd5, 1, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        ok_total += ok_n;
        n_cmp++; if (ok_total !== 2) begin n_fail++; $display("FAIL capture_oks got %0d want 2", ok_total); end
        rd(4'd0, 4'd5, v); n_cmp++; if (v !== 2'd2) begin n_fail++; $display("FAIL capture_dst got %0d want 2", v); end
        rd(4'd1, 4'd6, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL capture_src got %0d want 0", v); end
        rd(4'd0, 4'd1, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL capture_a_src got %0d want 0", v); end
        n_cmp++; if (bus.turn !== 1'b0) begin n_fail++; $display("FAIL capture_turn got %b want 0", bus.turn); end
    endtask

    task automatic test_go_held();
        int ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt;
        int pulses;
        logic [1:0] v;
        do_reset();
        run_move(4'd2, 4'd1, 4'd2, 4'd3, 10, ok_at, err_at, rearm_at, idle_at, ok_n, err_n, rearm_cnt);
        n_cmp++; if (ok_n !== 1 || err_n !== 0) begin n_fail++; $display("FAIL held_results got ok=%0d err=%0d want 1 0", ok_n, err_n); end
        // Second rise lands while COMMIT is in progress; coordinates also change after E0.
        pulses = 0;
        @(negedge clk); bus.go = 1'b0;
        @(negedge clk);
        bus.x1 = 4'd3; bus.y1 = 4'd6; bus.x2 = 4'd3; bus.y2 = 4'd5; bus.go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.move_ok || bus.move_err) pulses++;
            if (i == 0) begin bus.go = 1'b0; bus.y2 = 4'd4; end
            if (i == 1) bus.go = 1'b1;
        end
        bus.go = 1'b0;
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_rise got %0d results want 1", pulses); end
        rd(4'd3, 4'd5, v); n_cmp++; if (v !== 2'd2) begin n_fail++; $display("FAIL latched_dst got %0d want 2", v); end
        rd(4'd3, 4'd4, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL late_coord got %0d want 0", v); end
    endtask

    task automatic test_reset_commit();
        logic [1:0] v;
        do_reset();
        @(negedge clk); bus.go = 1'b0;
        @(negedge clk);
        bus.x1 = 4'd1; bus.y1 = 4'd1; bus.x2 = 4'd1; bus.y2 = 4'd2; bus.go = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++; if (bus.busy !== 1'b1 || bus.move_ok !== 1'b0) begin n_fail++; $display("FAIL commit_state got busy=%b ok=%b want 1 0", bus.busy, bus.move_ok); end
        bus.go = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.rearm_n !== 1'b1) begin n_fail++; $display("FAIL rst_commit_ctl got busy=%b rearm_n=%b want 0 1", bus.busy, bus.rearm_n); end
        rd(4'd1, 4'd1, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL rst_commit_src got %0d want 1", v); end
        rd(4'd1, 4'd2, v); n_cmp++; if (v !== 2'd0) begin n_fail++; $display("FAIL rst_commit_dst got %0d want 0", v); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.turn !== 1'b0) begin n_fail++; $display("FAIL rst_commit_after got busy=%b turn=%b want 0 0", bus.busy, bus.turn); end
        rd(4'd1, 4'd1, v); n_cmp++; if (v !== 2'd1) begin n_fail++; $display("FAIL rst_commit_after_src got %0d want 1", v); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.go = 1'b0;
        bus.x1 = 4'd0; bus.y1 = 4'd0; bus.x2 = 4'd0; bus.y2 = 4'd0;
        bus.rd_x = 4'd0; bus.rd_y = 4'd0;
        test_reset();
        test_valid_move();
        test_wrong_piece();
        test_errors();
        test_capture();
        test_go_held();
        test_reset_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
